// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache sequencer.
// Owns the valid/tag arrays, the miss/refill FSM and the read hit/miss counters.
module data_cache_controller #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned INDEX_W  = 3,
    parameter int unsigned OFFSET_W = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [ADDR_W-1:0]   word_address,
    output logic                stall,
    output logic [INDEX_W-1:0]  cache_index,
    output logic [OFFSET_W-1:0] cache_offset,
    output logic                cache_we,
    output logic                cache_fill,
    output logic                dm_req,
    output logic                dm_we,
    output logic [ADDR_W-1:0]   dm_address,
    input  logic                dm_ready,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_MEM,
        REFILL,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q [LINES];
    logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

    logic [INDEX_W-1:0]  addr_index;
    logic [OFFSET_W-1:0] addr_offset;
    logic [TAG_W-1:0]    addr_tag;
    logic                hit;

    logic                stall_c, cache_we_c, cache_fill_c, dm_req_c, dm_we_c;
    logic [ADDR_W-1:0]   dm_address_c;
    logic                hit_inc_c, miss_inc_c;

    assign addr_offset = word_address[OFFSET_W-1:0];
    assign addr_index  = word_address[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign addr_tag    = word_address[ADDR_W-1:OFFSET_W+INDEX_W];
    assign hit         = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);

    // Next-state and per-state outputs; IDLE outputs are Mealy on request/hit.
    always_comb begin
        state_d      = state_q;
        stall_c      = 1'b0;
        cache_we_c   = 1'b0;
        cache_fill_c = 1'b0;
        dm_req_c     = 1'b0;
        dm_we_c      = 1'b0;
        dm_address_c = '0;
        hit_inc_c    = 1'b0;
        miss_inc_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_write) begin
                    stall_c    = 1'b1;
                    cache_we_c = hit;
                    state_d    = WRITE_MEM;
                end else if (mem_read) begin
                    if (hit) begin
                        hit_inc_c = 1'b1;
                    end else begin
                        stall_c    = 1'b1;
                        miss_inc_c = 1'b1;
                        state_d    = REFILL;
                    end
                end
            end
            WRITE_MEM: begin
                stall_c      = 1'b1;
                dm_req_c     = 1'b1;
                dm_we_c      = 1'b1;
                dm_address_c = word_address;
                if (dm_ready) state_d = DONE;
            end
            REFILL: begin
                stall_c      = 1'b1;
                dm_req_c     = 1'b1;
                dm_address_c = {addr_tag, addr_index, OFFSET_W'(0)};
                if (dm_ready) begin
                    cache_fill_c = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All outputs are forced low while reset is asserted.
    assign stall        = stall_c & ~rst;
    assign cache_we     = cache_we_c & ~rst;
    assign cache_fill   = cache_fill_c & ~rst;
    assign dm_req       = dm_req_c & ~rst;
    assign dm_we        = dm_we_c & ~rst;
    assign dm_address   = rst ? '0 : dm_address_c;
    assign cache_index  = rst ? '0 : addr_index;
    assign cache_offset = rst ? '0 : addr_offset;
    assign hit_count    = rst ? '0 : hit_cnt_q;
    assign miss_count   = rst ? '0 : miss_cnt_q;

    // State register, valid bits and saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (cache_fill_c) valid_q[addr_index] <= 1'b1;
            if (hit_inc_c && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
            if (miss_inc_c && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    // Tag array has no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (cache_fill) tag_q[addr_index] <= addr_tag;
    end

endmodule

// File: tb/tb_data_cache_controller.sv
// Scoreboard bench for data_cache_controller with a behavioural cache model.
module tb_data_cache_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_read = 1'b1;
    logic       mem_write = 1'b0;
    logic [9:0] word_address = 10'h004;
    logic       dm_ready;

    logic        stall, cache_we, cache_fill, dm_req, dm_we;
    logic [2:0]  cache_index;
    logic [1:0]  cache_offset;
    logic [9:0]  dm_address;
    logic [15:0] hit_count, miss_count;

    logic        s_stall, s_cache_we, s_cache_fill, s_dm_req, s_dm_we;
    logic [2:0]  s_cache_index;
    logic [1:0]  s_cache_offset;
    logic [9:0]  s_dm_address;
    logic [2:0]  s_hit_count, s_miss_count;

    data_cache_controller dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .word_address(word_address), .stall(stall), .cache_index(cache_index),
        .cache_offset(cache_offset), .cache_we(cache_we), .cache_fill(cache_fill),
        .dm_req(dm_req), .dm_we(dm_we), .dm_address(dm_address), .dm_ready(dm_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // Narrow-counter instance to reach saturation quickly.
    data_cache_controller #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .word_address(word_address), .stall(s_stall), .cache_index(s_cache_index),
        .cache_offset(s_cache_offset), .cache_we(s_cache_we), .cache_fill(s_cache_fill),
        .dm_req(s_dm_req), .dm_we(s_dm_we), .dm_address(s_dm_address), .dm_ready(dm_ready),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stall_cyc;
        int we;
        int fill;
        int req;
        int dwe;
        int daddr;
        int hits;
        int misses;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   m_valid[8];
    int   m_tag[8];
    int   m_hits = 0;
    int   m_misses = 0;
    int   lat = 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    // Memory: ready in the lat-th cycle of dm_req; stray pulses while idle.
    initial begin
        int cnt = 0;
        dm_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dm_req) begin
                cnt++;
                dm_ready = (cnt == lat);
            end else begin
                cnt = 0;
                dm_ready = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: accumulate per-access observations, compare on completion.
    initial begin
        int   st = 0, fwe = 0, fad = 0, eh = 0, em = 0;
        bit   wes = 0, fills = 0, fillbad = 0, reqs = 0, unstable = 0, cnt_pend = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                st = 0; wes = 0; fills = 0; fillbad = 0; reqs = 0; unstable = 0; cnt_pend = 0;
            end else if (mem_read || mem_write) begin
                wes   |= cache_we;
                fills |= cache_fill;
                if (cache_fill && !dm_ready) fillbad = 1;
                if (dm_req) begin
                    if (!reqs) begin
                        reqs = 1; fwe = int'(dm_we); fad = int'(dm_address);
                    end else if (int'(dm_we) != fwe || int'(dm_address) != fad) begin
                        unstable = 1;
                    end
                end
                if (stall) begin
                    st++;
                end else begin
                    if (sb.size() == 0) begin
                        chk("unexpected_completion", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("stall_cycles", st, e.stall_cyc);
                        chk("cache_we", int'(wes), e.we);
                        chk("cache_fill", int'(fills), e.fill);
                        chk("fill_on_ready", int'(fillbad), 0);
                        chk("dm_req", int'(reqs), e.req);
                        if (e.req != 0) begin
                            chk("dm_we", fwe, e.dwe);
                            chk("dm_address", fad, e.daddr);
                            chk("dm_stable", int'(unstable), 0);
                        end
                        cnt_pend = 1; eh = e.hits; em = e.misses;
                    end
                    st = 0; wes = 0; fills = 0; fillbad = 0; reqs = 0; unstable = 0;
                end
            end else begin
                chk("idle_quiet", int'({stall, dm_req, cache_we, cache_fill}), 0);
                if (cnt_pend) begin
                    chk("hit_count", int'(hit_count), sat(eh, 65535));
                    chk("miss_count", int'(miss_count), sat(em, 65535));
                    chk("hit_count_sat", int'(s_hit_count), sat(eh, 7));
                    chk("miss_count_sat", int'(s_miss_count), sat(em, 7));
                    cnt_pend = 0;
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
        m_hits = 0;
        m_misses = 0;
    endtask

    // Predict the access from cache rules, then drive it until it completes.
    task automatic do_access(input bit wr, input logic [9:0] a, input int l);
        exp_t e;
        int   idx = int'(a[4:2]);
        int   tg  = int'(a[9:5]);
        bit   h   = m_valid[idx] && (m_tag[idx] == tg);
        int   n;
        e.stall_cyc = 0; e.we = 0; e.fill = 0; e.req = 0; e.dwe = 0; e.daddr = 0;
        if (wr) begin
            e.stall_cyc = 1 + l; e.we = int'(h); e.req = 1; e.dwe = 1; e.daddr = int'(a);
        end else if (h) begin
            m_hits++;
        end else begin
            e.stall_cyc = 1 + l; e.fill = 1; e.req = 1; e.daddr = int'(a) & ~3;
            m_misses++;
            m_valid[idx] = 1;
            m_tag[idx] = tg;
        end
        e.hits = m_hits;
        e.misses = m_misses;
        sb.push_back(e);
        lat = l;
        @(posedge clk);
        #1;
        word_address = a;
        mem_write = wr;
        mem_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 60);
        if (stall) chk("access_timeout", 1, 0);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        word_address = 10'($urandom);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Reset held with a read pending: pipeline must not stall or request.
        repeat (8) begin
            @(negedge clk);
            chk("reset_stall", int'(stall), 0);
            chk("reset_dm_req", int'(dm_req), 0);
            chk("reset_strobes", int'({cache_we, cache_fill}), 0);
        end
        chk("reset_counts", int'(hit_count) + int'(miss_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_read = 1'b0;

        do_access(1, 10'h004, 3);
        do_access(0, 10'h004, 3);
        do_access(0, 10'h004, 2);
        do_access(0, 10'h007, 1);
        do_access(1, 10'h005, 2);
        do_access(0, 10'h000, 1);
        do_access(0, 10'h100, 4);
        do_access(0, 10'h000, 2);

        // Reset in the middle of a refill abandons the transaction.
        lat = 20;
        @(posedge clk);
        #1;
        word_address = 10'h0C8;
        mem_read = 1'b1;
        repeat (2) @(negedge clk);
        chk("refill_dm_req", int'(dm_req), 1);
        chk("refill_dm_address", int'(dm_address), 10'h0C8);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_dm_req", int'(dm_req), 0);
        chk("rst_stall", int'(stall), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_read = 1'b0;
        model_reset();
        @(negedge clk);
        chk("post_rst_dm_req", int'(dm_req), 0);
        chk("post_rst_miss_count", int'(miss_count), 0);
        do_access(0, 10'h0C8, 2);
        do_access(0, 10'h0C8, 1);

        // Randomized mix over a small tag pool so hits, conflicts and saturation occur.
        for (int i = 0; i < 90; i++) begin
            logic [9:0] a;
            a = {5'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            do_access(($urandom_range(0, 2) == 0), a, $urandom_range(1, 4));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
